// File: rtl/vga_sprite_sequencer_pkg.sv
// Shared definitions for the VGA sprite sequencer.
//   - state_e      : drawing sequencer states
//   - IMG_*        : ROM mux (image_sel) encodings; the background and
//                    game-over codes depend on the card count, so they are
//                    provided as helper functions
//   - DEF_*        : default geometry / timing constants
package vga_sprite_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAW_BG,
      S_DRAW_SPRITE,
      S_MOVE_WAIT,
      S_DRAW_GO,
      S_GO_HOLD
   } state_e;

   localparam int DEF_SCREEN_W    = 160;
   localparam int DEF_SCREEN_H    = 120;
   localparam int DEF_SPRITE_W    = 20;
   localparam int DEF_SPRITE_H    = 40;
   localparam int DEF_NUM_SPRITES = 7;
   localparam int DEF_COLOUR_W    = 9;
   localparam int DEF_MOVE_DIV    = 10000500;
   localparam int DEF_HOLD_CYCLES = 250000000;

   localparam int IMG_START     = 0;
   localparam int IMG_CARD_BASE = 1;

   function automatic int img_bg(input int num_sprites);
      return num_sprites + 1;
   endfunction

   function automatic int img_go(input int num_sprites);
      return num_sprites + 2;
   endfunction

endpackage

// File: rtl/vga_sprite_sequencer_if.sv
// ROM / VGA pixel bus of the sprite sequencer.
//   master (sequencer): drives image_sel, screen_addr, sprite_addr,
//                       colour, x_plot, y_plot, plot; receives rom_pixel
//   slave  (ROM mux + VGA adapter): the mirror image
interface vga_sprite_sequencer_if #(
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int SPRITE_W    = 20,
   parameter int SPRITE_H    = 40,
   parameter int NUM_SPRITES = 7,
   parameter int COLOUR_W    = 9
);
   localparam int XW  = $clog2(SCREEN_W);
   localparam int YW  = $clog2(SCREEN_H);
   localparam int SAW = $clog2(SCREEN_W*SCREEN_H);
   localparam int PAW = $clog2(SPRITE_W*SPRITE_H);
   localparam int ISW = $clog2(NUM_SPRITES+3);

   logic [ISW-1:0]      image_sel;
   logic [SAW-1:0]      screen_addr;
   logic [PAW-1:0]      sprite_addr;
   logic [COLOUR_W-1:0] rom_pixel;
   logic [COLOUR_W-1:0] colour;
   logic [XW-1:0]       x_plot;
   logic [YW-1:0]       y_plot;
   logic                plot;

   modport master (
      output image_sel, screen_addr, sprite_addr, colour, x_plot, y_plot, plot,
      input  rom_pixel
   );

   modport slave (
      input  image_sel, screen_addr, sprite_addr, colour, x_plot, y_plot, plot,
      output rom_pixel
   );
endinterface

// File: rtl/vga_sprite_sequencer_raster_counter.sv
// raster_counter: W x H column/row scan counter, column fastest.
//   clock, resetn : clock, synchronous active-low reset
//   clr_i         : return to (0,0); wins over en_i
//   en_i          : advance one position, wrapping to (0,0) after the last
//   col_o, row_o  : current position
//   last_o        : current position is (W-1, H-1)
//   addr_o        : linear address row*W+col (kept as its own register so
//                   no multiplier is needed)
module raster_counter #(
   parameter  int W  = 160,
   parameter  int H  = 120,
   localparam int CW = (W > 1) ? $clog2(W) : 1,
   localparam int RW = (H > 1) ? $clog2(H) : 1,
   localparam int AW = (W*H > 1) ? $clog2(W*H) : 1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] col_o,
   output logic [RW-1:0] row_o,
   output logic          last_o,
   output logic [AW-1:0] addr_o
);
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [AW-1:0] addr_q;
   logic          col_end, row_end;

   assign col_end = (col_q == CW'(W-1));
   assign row_end = (row_q == RW'(H-1));

   always_ff @(posedge clock) begin
      if (!resetn || clr_i) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else if (en_i) begin
         if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
         addr_q <= (col_end && row_end) ? '0 : addr_q + AW'(1);
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign last_o = col_end && row_end;
   assign addr_o = addr_q;
endmodule

// File: rtl/vga_sprite_sequencer.sv
// vga_sprite_sequencer: draws full-screen images (start, background,
// game-over), overlays one moving card sprite per frame and feeds every
// pixel to the VGA adapter.
//   clock, resetn        : clock, synchronous active-low reset
//   start                : leave the start screen and begin play (IDLE only)
//   show_game_over       : abort play into the game-over screen
//   sprite_id, sprite_y  : card and top row, captured on DRAW_SPRITE entry
//   sprite_x             : current sprite left column
//   frame_done           : pulse after each sprite step
//   game_over_done       : pulse on leaving the game-over hold
//   bus (master)         : ROM address/select out, rom_pixel in one cycle
//                          later, VGA colour/x/y/plot out
module vga_sprite_sequencer
   import vga_sprite_sequencer_pkg::*;
#(
   parameter  int SCREEN_W    = DEF_SCREEN_W,
   parameter  int SCREEN_H    = DEF_SCREEN_H,
   parameter  int SPRITE_W    = DEF_SPRITE_W,
   parameter  int SPRITE_H    = DEF_SPRITE_H,
   parameter  int NUM_SPRITES = DEF_NUM_SPRITES,
   parameter  int COLOUR_W    = DEF_COLOUR_W,
   parameter  logic [COLOUR_W-1:0] TRANSPARENT = COLOUR_W'(9'h1FF),
   parameter  int MOVE_DIV    = DEF_MOVE_DIV,
   parameter  int STEP        = 1,
   parameter  int HOLD_CYCLES = DEF_HOLD_CYCLES,
   localparam int XW  = $clog2(SCREEN_W),
   localparam int YW  = $clog2(SCREEN_H),
   localparam int IDW = $clog2(NUM_SPRITES),
   localparam int ISW = $clog2(NUM_SPRITES+3),
   localparam int SCW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
   localparam int SRW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
   localparam int SAW = $clog2(SCREEN_W*SCREEN_H),
   localparam int PAW = $clog2(SPRITE_W*SPRITE_H)
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   input  logic           show_game_over,
   input  logic [IDW-1:0] sprite_id,
   input  logic [YW-1:0]  sprite_y,
   output logic [XW-1:0]  sprite_x,
   output logic           frame_done,
   output logic           game_over_done,
   vga_sprite_sequencer_if.master bus
);
   state_e         state_q;
   logic [31:0]    wcnt_q;
   logic [XW-1:0]  sprite_x_q;
   logic [IDW-1:0] id_q;
   logic [YW-1:0]  sy_q;
   logic           plot_q, key_q, frame_done_q, go_done_q;
   logic [XW-1:0]  xp_q;
   logic [YW-1:0]  yp_q;

   // pixel pipeline next-state
   logic           plot_d, key_d;
   logic [XW-1:0]  xp_d;
   logic [YW-1:0]  yp_d;

   logic           abort, go_start, scr_en, scr_clr, spr_en;
   logic [XW-1:0]  scr_col;
   logic [YW-1:0]  scr_row;
   logic [SAW-1:0] scr_addr;
   logic           scr_last;
   logic [SCW-1:0] spr_col;
   logic [SRW-1:0] spr_row;
   logic [PAW-1:0] spr_addr;
   logic           spr_last;
   logic [XW:0]    sx_w;
   logic [YW:0]    sy_w;
   logic           vis;
   logic [31:0]    nx;
   logic [XW-1:0]  next_x;

   // show_game_over only counts during play and overrides every other move
   assign abort    = show_game_over &&
                     (state_q == S_DRAW_BG || state_q == S_DRAW_SPRITE ||
                      state_q == S_MOVE_WAIT);
   assign go_start = start && (state_q == S_IDLE);
   assign scr_en   = (state_q == S_IDLE) || (state_q == S_DRAW_BG) ||
                     (state_q == S_DRAW_GO);
   assign scr_clr  = go_start || abort;
   assign spr_en   = (state_q == S_DRAW_SPRITE);

   raster_counter #(.W(SCREEN_W), .H(SCREEN_H)) u_scr (
      .clock  (clock),
      .resetn (resetn),
      .clr_i  (scr_clr),
      .en_i   (scr_en),
      .col_o  (scr_col),
      .row_o  (scr_row),
      .last_o (scr_last),
      .addr_o (scr_addr)
   );

   raster_counter #(.W(SPRITE_W), .H(SPRITE_H)) u_spr (
      .clock  (clock),
      .resetn (resetn),
      .clr_i  (abort),
      .en_i   (spr_en),
      .col_o  (spr_col),
      .row_o  (spr_row),
      .last_o (spr_last),
      .addr_o (spr_addr)
   );

   // One bit of headroom so off-screen sprite pixels are clipped rather
   // than wrapping back onto the left/top edge.
   assign sx_w = {1'b0, sprite_x_q} + (XW+1)'(spr_col);
   assign sy_w = {1'b0, sy_q} + (YW+1)'(spr_row);
   assign vis  = (sx_w < (XW+1)'(SCREEN_W)) && (sy_w < (YW+1)'(SCREEN_H));

   assign nx     = 32'(sprite_x_q) + 32'(STEP);
   assign next_x = (nx >= 32'(SCREEN_W)) ? '0 : nx[XW-1:0];

   always_comb begin
      plot_d = 1'b0;
      key_d  = 1'b0;
      xp_d   = scr_col;
      yp_d   = scr_row;
      case (state_q)
         S_IDLE, S_DRAW_BG, S_DRAW_GO: plot_d = 1'b1;
         S_DRAW_SPRITE: begin
            plot_d = vis;
            key_d  = 1'b1;
            xp_d   = sx_w[XW-1:0];
            yp_d   = sy_w[YW-1:0];
         end
         default: plot_d = 1'b0;
      endcase
      if (abort) plot_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         wcnt_q       <= '0;
         sprite_x_q   <= '0;
         id_q         <= '0;
         sy_q         <= '0;
         plot_q       <= 1'b0;
         key_q        <= 1'b0;
         xp_q         <= '0;
         yp_q         <= '0;
         frame_done_q <= 1'b0;
         go_done_q    <= 1'b0;
      end else begin
         plot_q       <= plot_d;
         key_q        <= key_d;
         xp_q         <= xp_d;
         yp_q         <= yp_d;
         frame_done_q <= 1'b0;
         go_done_q    <= 1'b0;
         if (abort) begin
            state_q <= S_DRAW_GO;
            wcnt_q  <= '0;
         end else begin
            case (state_q)
               S_IDLE:
                  if (start) state_q <= S_DRAW_BG;
               S_DRAW_BG:
                  if (scr_last) begin
                     state_q <= S_DRAW_SPRITE;
                     id_q    <= sprite_id;
                     sy_q    <= sprite_y;
                  end
               S_DRAW_SPRITE:
                  if (spr_last) state_q <= S_MOVE_WAIT;
               S_MOVE_WAIT:
                  if (wcnt_q == 32'(MOVE_DIV-1)) begin
                     wcnt_q       <= '0;
                     sprite_x_q   <= next_x;
                     frame_done_q <= 1'b1;
                     state_q      <= S_DRAW_BG;
                  end else begin
                     wcnt_q <= wcnt_q + 32'd1;
                  end
               S_DRAW_GO:
                  if (scr_last) state_q <= S_GO_HOLD;
               S_GO_HOLD:
                  if (wcnt_q == 32'(HOLD_CYCLES-1)) begin
                     wcnt_q     <= '0;
                     sprite_x_q <= '0;
                     go_done_q  <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     wcnt_q <= wcnt_q + 32'd1;
                  end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      case (state_q)
         S_IDLE:             bus.image_sel = ISW'(IMG_START);
         S_DRAW_SPRITE:      bus.image_sel = ISW'(IMG_CARD_BASE) + ISW'(id_q);
         S_DRAW_GO, S_GO_HOLD: bus.image_sel = ISW'(img_go(NUM_SPRITES));
         default:            bus.image_sel = ISW'(img_bg(NUM_SPRITES));
      endcase
   end

   assign bus.screen_addr = scr_addr;
   assign bus.sprite_addr = spr_addr;
   // Transparency can only be judged once the ROM data arrives, so the
   // registered plot is gated here by the keyed-pixel flag.
   assign bus.plot        = plot_q && !(key_q && (bus.rom_pixel == TRANSPARENT));
   assign bus.colour      = plot_q ? bus.rom_pixel : '0;
   assign bus.x_plot      = xp_q;
   assign bus.y_plot      = yp_q;

   assign sprite_x       = sprite_x_q;
   assign frame_done     = frame_done_q;
   assign game_over_done = go_done_q;
endmodule
